// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width and the 3-bit opcode encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_ADD = 3'b001,
    OP_SLL = 3'b010,
    OP_SRL = 3'b011,
    OP_SUB = 3'b100,
    OP_SLT = 3'b101,
    OP_ABS = 3'b110,
    OP_SEQ = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; compare ops report their outcome on zero_o.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic [2:0]        opcode_i,
  output logic [DATA_W-1:0] alu_result_o,
  output logic              zero_o
);

  logic set_flag;

  always_comb begin
    alu_result_o = '0;
    set_flag     = 1'b0;
    case (opcode_i)
      OP_AND: alu_result_o = rs_i & rt_i;
      OP_ADD: alu_result_o = rs_i + rt_i;
      OP_SLL: alu_result_o = rs_i << rt_i;
      OP_SRL: alu_result_o = rs_i >> 1;
      OP_SUB: alu_result_o = rs_i - rt_i;
      OP_SLT: begin
        set_flag     = ($signed(rs_i) < $signed(rt_i));
        alu_result_o = {{(DATA_W-1){1'b0}}, set_flag};
      end
      OP_ABS: alu_result_o = rs_i[DATA_W-1] ? (~rs_i + 1'b1) : rs_i;
      OP_SEQ: begin
        set_flag     = (rs_i == rt_i);
        alu_result_o = {{(DATA_W-1){1'b0}}, set_flag};
      end
      default: alu_result_o = '0;
    endcase
  end

  // SLT/SEQ drive the flag with the comparison, everything else flags a zero result.
  assign zero_o = ((opcode_i == OP_SLT) || (opcode_i == OP_SEQ)) ? set_flag
                                                                   : (alu_result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, each with a
// one-entry registered response slot, plus an accepted-operation counter.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req0_valid_i,
  output logic               req0_ready_o,
  input  logic [DATA_W-1:0]  req0_rs_i,
  input  logic [DATA_W-1:0]  req0_rt_i,
  input  logic [2:0]         req0_opcode_i,
  input  logic               req1_valid_i,
  output logic               req1_ready_o,
  input  logic [DATA_W-1:0]  req1_rs_i,
  input  logic [DATA_W-1:0]  req1_rt_i,
  input  logic [2:0]         req1_opcode_i,
  output logic               resp0_valid_o,
  input  logic               resp0_ready_i,
  output logic [DATA_W-1:0]  resp0_result_o,
  output logic               resp0_zero_o,
  output logic               resp1_valid_o,
  input  logic               resp1_ready_i,
  output logic [DATA_W-1:0]  resp1_result_o,
  output logic               resp1_zero_o,
  output logic [COUNT_W-1:0] op_count_o
);

  logic [1:0]              req_valid;
  logic [1:0]              resp_ready;
  logic [1:0]              slot_elig;
  logic [1:0]              cand;
  logic [1:0]              grant;

  logic [DATA_W-1:0]       alu_rs;
  logic [DATA_W-1:0]       alu_rt;
  logic [2:0]              alu_op;
  logic [DATA_W-1:0]       alu_result;
  logic                    alu_zero;

  logic [1:0]              resp_valid_q, resp_valid_d;
  logic [1:0][DATA_W-1:0]  resp_result_q, resp_result_d;
  logic [1:0]              resp_zero_q, resp_zero_d;
  logic                    last_grant_q, last_grant_d;
  logic [COUNT_W-1:0]      op_count_q, op_count_d;

  assign req_valid  = {req1_valid_i, req0_valid_i};
  assign resp_ready = {resp1_ready_i, resp0_ready_i};

  always_comb begin
    slot_elig = ~resp_valid_q | resp_ready;
    cand      = req_valid & slot_elig & {2{~reset_i}};
    grant     = cand;
    // On contention the requester that did not win last time goes first.
    if (cand == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  always_comb begin
    alu_rs = '0;
    alu_rt = '0;
    alu_op = OP_AND;
    if (grant[0]) begin
      alu_rs = req0_rs_i;
      alu_rt = req0_rt_i;
      alu_op = req0_opcode_i;
    end else if (grant[1]) begin
      alu_rs = req1_rs_i;
      alu_rt = req1_rt_i;
      alu_op = req1_opcode_i;
    end
  end

  alu u_alu (
    .rs_i         (alu_rs),
    .rt_i         (alu_rt),
    .opcode_i     (alu_op),
    .alu_result_o (alu_result),
    .zero_o       (alu_zero)
  );

  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    last_grant_d  = last_grant_q;
    op_count_d    = op_count_q;
    for (int unsigned n = 0; n < 2; n++) begin
      // A same-cycle grant wins over the drain, so the slot reloads and stays valid.
      if (grant[n]) begin
        resp_valid_d[n]  = 1'b1;
        resp_result_d[n] = alu_result;
        resp_zero_d[n]   = alu_zero;
      end else if (resp_valid_q[n] && resp_ready[n]) begin
        resp_valid_d[n] = 1'b0;
      end
    end
    if (grant != 2'b00) begin
      last_grant_d = grant[1];
      op_count_d   = op_count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= '0;
      last_grant_q  <= 1'b1;
      op_count_q    <= '0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      last_grant_q  <= last_grant_d;
      op_count_q    <= op_count_d;
    end
  end

  assign resp0_valid_o  = resp_valid_q[0];
  assign resp1_valid_o  = resp_valid_q[1];
  assign resp0_result_o = resp_result_q[0];
  assign resp1_result_o = resp_result_q[1];
  assign resp0_zero_o   = resp_zero_q[0];
  assign resp1_zero_o   = resp_zero_q[1];
  assign op_count_o     = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: per-cycle reference model with response scoreboards,
// an opcode vector table, and directed arbitration/reset/wrap sequences.
module tb_alu_arbiter;

  localparam int unsigned CW = 4;

  typedef struct {
    logic [7:0] res;
    logic       z;
  } exp_t;

  typedef struct {
    int unsigned port;
    logic [2:0]  op;
    logic [7:0]  rs;
    logic [7:0]  rt;
    logic [7:0]  res;
    logic        z;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    resp_ready;
  logic [7:0]    req_rs [2];
  logic [7:0]    req_rt [2];
  logic [2:0]    req_op [2];

  logic          rdy0, rdy1, rv0, rv1, rz0, rz1;
  logic [7:0]    rr0, rr1;
  logic [CW-1:0] op_count;

  exp_t        sb0[$];
  exp_t        sb1[$];
  int unsigned m_count;
  logic        m_last;
  logic [1:0]  last_g;
  int unsigned n_pass;
  int unsigned n_total;
  vec_t        tbl[15];

  always #5 clk = ~clk;

  alu_arbiter #(.COUNT_W(CW)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .req0_valid_i   (req_valid[0]),
    .req0_ready_o   (rdy0),
    .req0_rs_i      (req_rs[0]),
    .req0_rt_i      (req_rt[0]),
    .req0_opcode_i  (req_op[0]),
    .req1_valid_i   (req_valid[1]),
    .req1_ready_o   (rdy1),
    .req1_rs_i      (req_rs[1]),
    .req1_rt_i      (req_rt[1]),
    .req1_opcode_i  (req_op[1]),
    .resp0_valid_o  (rv0),
    .resp0_ready_i  (resp_ready[0]),
    .resp0_result_o (rr0),
    .resp0_zero_o   (rz0),
    .resp1_valid_o  (rv1),
    .resp1_ready_i  (resp_ready[1]),
    .resp1_result_o (rr1),
    .resp1_zero_o   (rz1),
    .op_count_o     (op_count)
  );

  function automatic exp_t alu_ref(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    exp_t e;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = 8'(a + b);
      3'd2: e.res = (b >= 8) ? 8'h00 : 8'(a << b[2:0]);
      3'd3: e.res = {1'b0, a[7:1]};
      3'd4: e.res = 8'(a - b);
      3'd5: e.res = {7'b0, ($signed(a) < $signed(b))};
      3'd6: e.res = a[7] ? 8'(0 - a) : a;
      default: e.res = {7'b0, (a == b)};
    endcase
    e.z = (op == 3'd5 || op == 3'd7) ? e.res[0] : (e.res == 8'h00);
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: compare outputs with the model at negedge, advance model, return at posedge+1.
  task automatic step();
    logic [1:0] sbv, elig, cand, g;
    @(negedge clk);
    chk("op_count", 32'(op_count), 32'(m_count % (1 << CW)));
    sbv = {sb1.size() != 0, sb0.size() != 0};
    chk("resp0_valid", 32'(rv0), 32'(sbv[0]));
    chk("resp1_valid", 32'(rv1), 32'(sbv[1]));
    if (sbv[0]) begin
      chk("resp0_result", 32'(rr0), 32'(sb0[0].res));
      chk("resp0_zero", 32'(rz0), 32'(sb0[0].z));
    end
    if (sbv[1]) begin
      chk("resp1_result", 32'(rr1), 32'(sb1[0].res));
      chk("resp1_zero", 32'(rz1), 32'(sb1[0].z));
    end
    elig = ~sbv | resp_ready;
    cand = rst ? 2'b00 : (req_valid & elig);
    g = cand;
    if (cand == 2'b11) g = m_last ? 2'b01 : 2'b10;
    chk("req0_ready", 32'(rdy0), 32'(g[0]));
    chk("req1_ready", 32'(rdy1), 32'(g[1]));
    last_g = {rdy1, rdy0};
    if (sbv[0] && resp_ready[0]) void'(sb0.pop_front());
    if (sbv[1] && resp_ready[1]) void'(sb1.pop_front());
    if (g[0]) sb0.push_back(alu_ref(req_op[0], req_rs[0], req_rt[0]));
    if (g[1]) sb1.push_back(alu_ref(req_op[1], req_rs[1], req_rt[1]));
    if (g != 2'b00) begin
      m_count++;
      m_last = g[1];
    end
    if (rst) begin
      sb0.delete();
      sb1.delete();
      m_count = 0;
      m_last  = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int unsigned p, logic v, logic [2:0] op, logic [7:0] a, logic [7:0] b);
    req_valid[p] = v;
    req_op[p]    = op;
    req_rs[p]    = a;
    req_rt[p]    = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; m_count = 0; m_last = 1'b1;
    rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b11;
    set_req(0, 1'b0, 3'd0, 8'd0, 8'd0);
    set_req(1, 1'b0, 3'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    // Reset held with requests present: no grants.
    req_valid = 2'b11;
    step();
    chk("rst_result0", 32'(rr0), 32'd0);
    chk("rst_zero1", 32'(rz1), 32'd0);
    rst = 1'b0;
    req_valid = 2'b00;
    step();

    tbl[0]  = '{0, 3'd1, 8'd20,  8'd100, 8'd120, 1'b0};
    tbl[1]  = '{0, 3'd0, 8'hFF,  8'hAA,  8'hAA,  1'b0};
    tbl[2]  = '{1, 3'd4, 8'd253, 8'd250, 8'd3,   1'b0};
    tbl[3]  = '{0, 3'd4, 8'd5,   8'd6,   8'hFF,  1'b0};
    tbl[4]  = '{1, 3'd4, 8'd7,   8'd7,   8'd0,   1'b1};
    tbl[5]  = '{0, 3'd2, 8'd5,   8'd2,   8'd20,  1'b0};
    tbl[6]  = '{0, 3'd2, 8'd5,   8'd255, 8'd0,   1'b1};
    tbl[7]  = '{1, 3'd3, 8'h81,  8'd0,   8'h40,  1'b0};
    tbl[8]  = '{1, 3'd7, 8'hFF,  8'hFF,  8'd1,   1'b1};
    tbl[9]  = '{1, 3'd5, 8'd1,   8'd1,   8'd0,   1'b0};
    tbl[10] = '{1, 3'd5, 8'd2,   8'd5,   8'd1,   1'b1};
    tbl[11] = '{0, 3'd6, 8'hFB,  8'd0,   8'd5,   1'b0};
    tbl[12] = '{0, 3'd6, 8'h80,  8'd0,   8'h80,  1'b0};
    tbl[13] = '{1, 3'd1, 8'd200, 8'd100, 8'd44,  1'b0};
    tbl[14] = '{0, 3'd0, 8'h0F,  8'hF0,  8'd0,   1'b1};

    foreach (tbl[i]) begin
      req_valid = 2'b00;
      set_req(tbl[i].port, 1'b1, tbl[i].op, tbl[i].rs, tbl[i].rt);
      step();
      chk("tbl_granted", 32'(last_g), (tbl[i].port == 0) ? 32'd1 : 32'd2);
      req_valid = 2'b00;
      if (tbl[i].port == 0) begin
        chk("tbl_valid0", 32'(rv0), 32'd1);
        chk("tbl_result0", 32'(rr0), 32'(tbl[i].res));
        chk("tbl_zero0", 32'(rz0), 32'(tbl[i].z));
      end else begin
        chk("tbl_valid1", 32'(rv1), 32'd1);
        chk("tbl_result1", 32'(rr1), 32'(tbl[i].res));
        chk("tbl_zero1", 32'(rz1), 32'(tbl[i].z));
      end
      step();
    end

    // Contention after reset alternates 0,1,0,1...
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 3'd0, 8'hFF, 8'hAA);
    set_req(1, 1'b1, 3'd4, 8'd253, 8'd250);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt_grant", 32'(last_g), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    chk("alt_result0", 32'(rr0), 32'hAA);
    chk("alt_result1", 32'(rr1), 32'd3);

    // Backpressure on slot 0: requester 1 takes every cycle.
    resp_ready[0] = 1'b0;
    step();
    chk("bp_load", 32'(last_g), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_grant1", 32'(last_g), 32'd2);
      chk("bp_hold0", 32'(rr0), 32'hAA);
    end
    resp_ready[0] = 1'b1;
    step();
    chk("bp_reload_grant", 32'(last_g), 32'd1);
    chk("bp_reload_valid", 32'(rv0), 32'd1);
    req_valid = 2'b00;
    repeat (2) step();

    // Reset in what would be a grant cycle.
    set_req(0, 1'b1, 3'd1, 8'd1, 8'd2);
    set_req(1, 1'b1, 3'd1, 8'd3, 8'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 32'({rv1, rv0}), 32'd0);
    chk("rst_mid_count", 32'(op_count), 32'd0);
    step();
    chk("rst_first_grant", 32'(last_g), 32'd1);
    req_valid = 2'b00;
    repeat (2) step();

    // Counter wrap with a 4-bit counter.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 3'd1, 8'd1, 8'd1);
    for (int i = 0; i < 17; i++) step();
    req_valid = 2'b00;
    chk("wrap_count", 32'(op_count), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
